serial_sub_8_bit: RTL and testbench

- Bit-serial 8-bit subtractor: computes diff = a - b - bin, LSB first, one bit per clock, using a single full-adder cell on a + ~b + ~bin.
- It is the sequential inverse-operation companion to the team's combinational 8-bit ripple-carry adder.
- It sits beside that adder in the lab ALU datapath; a start/done handshake brackets each operation.

---
 rtl/serial_sub_pkg.sv | 6 +
 rtl/full_adder_cell.sv | 12 +
 rtl/serial_sub_8_bit.sv | 75 +++++++
 tb/tb_serial_sub_8_bit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared width, counter width and FSM state type for the serial subtractor
package serial_sub_pkg;
    localparam int SUB_WIDTH = 8;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder
// ports: a, b, cin -> s (sum), cout (carry-out)
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_sub_8_bit.sv
// serial_sub_8_bit: bit-serial diff = a - b - bin, LSB first, one bit per clock
// ports: clk, rst_n (async active-low), start, a, b, bin -> busy, done, diff, bout,
//        ovf (only when SERIAL_SUB_OVF_EN is defined)
module serial_sub_8_bit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    sub_state_t state;
    logic [WIDTH-1:0] a_sr, b_sr, part;
    logic [CNT_W-1:0] cnt;
    logic carry, s, cout;
    // subtraction as a + ~b + ~bin: b inverted here, borrow-in inverted into the initial carry
    full_adder_cell fa (.a(a_sr[0]), .b(~b_sr[0]), .cin(carry), .s(s), .cout(cout));
    assign busy = state == SHIFT;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr <= '0;
            b_sr <= '0;
            part <= '0;
            cnt <= '0;
            carry <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr <= a;
                    b_sr <= b;
                    carry <= ~bin;
                    cnt <= '0;
                    part <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    carry <= cout;
                    part <= {s, part[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        diff <= {s, part[WIDTH-1:1]};
                        bout <= ~cout;
`ifdef SERIAL_SUB_OVF_EN
                        // carry still holds the carry into the MSB here
                        ovf <= carry ^ cout;
`endif
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_8_bit.sv
// tb_serial_sub_8_bit: scoreboard bench for serial_sub_8_bit
module tb_serial_sub_8_bit;
    typedef struct {
        logic [7:0] d;
        logic bo;
        logic ov;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n, start, bin, busy, done, bout;
    logic [7:0] a, b, diff;
`ifdef SERIAL_SUB_OVF_EN
    logic ovf;
`endif
    exp_t sb[$];
    int checks = 0, errs = 0, cyc = 0, ndone = 0;
    int done_t[$];
    logic [7:0] last_diff = 8'h00;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    serial_sub_8_bit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic z);
        exp_t m;
        logic [8:0] r;
        int sr;
        r = {1'b0, x} - {1'b0, y} - {8'h00, z};
        sr = int'($signed(x)) - int'($signed(y)) - int'(z);
        m.d = r[7:0];
        m.bo = r[8];
        m.ov = (sr < -128) || (sr > 127);
        return m;
    endfunction
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            ndone++;
            done_t.push_back(cyc);
            checks++;
            assert (sb.size() != 0) else begin
                errs++;
                $error("FAIL unexpected_done: observed done=1 expected no pending result");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_diff", diff, e.d);
                chk("sb_bout", bout, e.bo);
`ifdef SERIAL_SUB_OVF_EN
                chk("sb_ovf", ovf, e.ov);
`endif
            end
        end
    end
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic z);
        int lat = 0, bc = 0;
        @(negedge clk);
        a = x; b = y; bin = z; start = 1'b1;
        sb.push_back(model(x, y, z));
        @(posedge clk);
        #1;
        start = 1'b0; a = ~x; b = ~y; bin = ~z;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (k == 4) chk("hold_diff", diff, last_diff);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 9);
        chk("busy_cycles", bc, 8);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("diff_held", diff, model(x, y, z).d);
        last_diff = model(x, y, z).d;
    endtask
    initial begin
        int n0;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        do_op(8'h3F, 8'h55, 1'b0);
        do_op(8'h55, 8'h3F, 1'b0);
        do_op(8'h10, 8'h0F, 1'b1);
        do_op(8'h00, 8'h01, 1'b0);
        do_op(8'h80, 8'h01, 1'b0);
        chk("model_wrap", model(8'h00, 8'h01, 1'b0).d, 8'hFF);
        // start held high with operands changing every cycle; accepts land 10 edges apart
        n0 = ndone;
        done_t.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b1;
            a = 8'(i * 37 + 5);
            b = 8'(i * 91 + 17);
            bin = i[0];
            if (i % 10 == 0) sb.push_back(model(a, b, bin));
            if (i == 15) chk("held_hold_diff", diff, model(8'(5), 8'(17), 1'b0).d);
            @(posedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_done_count", ndone - n0, 3);
        if (done_t.size() >= 3) begin
            chk("held_gap1", done_t[1] - done_t[0], 10);
            chk("held_gap2", done_t[2] - done_t[1], 10);
        end
        chk("held_sb_empty", sb.size(), 0);
        // abort mid-operation with an asynchronous reset
        n0 = ndone;
        @(negedge clk);
        a = 8'h5A; b = 8'h33; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 8'h00);
        chk("abort_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_ovf", ovf, 0);
`endif
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", ndone - n0, 0);
        last_diff = 8'h00;
        do_op(8'h01, 8'h01, 1'b0);
        chk("final_bout", bout, 0);
        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
